// File: rtl/sort4_seq_if.sv
// Handshake and data bundle between the ALU sequencer and the sort4_seq engine.
interface sort4_seq_if;
    logic        start;
    logic        desc;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;
    logic        done;

    modport master (output start, desc, din, input dout, busy, done);
    modport slave  (input start, desc, din, output dout, busy, done);
endinterface

// File: rtl/sort4_seq.sv
// Four-byte sorter: one shared unsigned compare-and-swap per clock over a fixed
// six-step bubble schedule, so latency is data independent.
module ge8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       ge
);
    assign ge = (a >= b);
endmodule

module sort4_seq (
    input  logic        clk,
    input  logic        rst,
    sort4_seq_if.slave  bus
);
    typedef enum logic {IDLE, SORT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [3:0][7:0] r_q, r_d;
    logic            desc_q, desc_d;
    logic [31:0]     dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [1:0]      idx;
    logic [7:0]      op_a, op_b;
    logic            ge;
    logic            swap;

    // Pair schedule: three passes of shrinking length, (0,1)(1,2)(2,3) (0,1)(1,2) (0,1)
    always_comb begin
        case (step_q)
            3'd0:    idx = 2'd0;
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd3:    idx = 2'd0;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    assign op_a = r_q[idx];
    assign op_b = r_q[idx + 2'd1];

    ge8 u_ge8 (.a(op_a), .b(op_b), .ge(ge));

    assign swap = desc_q ? ~ge : ge;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        r_d     = r_q;
        desc_d  = desc_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    r_d     = bus.din;
                    desc_d  = bus.desc;
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SORT;
                end
            end
            SORT: begin
                if (swap) begin
                    r_d[idx]        = op_b;
                    r_d[idx + 2'd1] = op_a;
                end
                step_d = step_q + 3'd1;
                // Last step publishes the post-swap word on the same edge.
                if (step_q == 3'd5) begin
                    dout_d  = r_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            r_q     <= '0;
            desc_q  <= 1'b0;
            dout_q  <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            r_q     <= r_d;
            desc_q  <= desc_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_sort4_seq.sv
// Directed and randomized bench for sort4_seq; outputs sampled on the falling edge.
module tb_sort4_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sort4_seq_if bus ();
    sort4_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: selection sort over the unpacked bytes.
    function automatic logic [31:0] ref_sort(input logic [31:0] d, input logic ds);
        logic [7:0] e [4];
        logic [7:0] t;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) e[k] = d[8*k +: 8];
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 4; b++)
                if (ds ? (e[b] > e[a]) : (e[b] < e[a])) begin
                    t = e[a]; e[a] = e[b]; e[b] = t;
                end
        for (int k = 0; k < 4; k++) r[8*k +: 8] = e[k];
        return r;
    endfunction

    // Launch one sort and wait (bounded) for done; lat counts edges after the start edge.
    task automatic do_sort(input logic [31:0] d, input logic ds,
                           output logic [31:0] res, output int lat, output int bcyc,
                           output logic busy_at_done);
        @(negedge clk);
        bus.din = d; bus.desc = ds; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; bcyc = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        res = bus.dout;
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.desc = 1'b0; bus.din = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.dout} !== 34'h0) begin
            bad++; $display("FAIL reset_hold got busy=%b done=%b dout=%h want 0 0 0", bus.busy, bus.done, bus.dout);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.dout} !== 34'h0) begin
            bad++; $display("FAIL reset_idle got busy=%b done=%b dout=%h want 0 0 0", bus.busy, bus.done, bus.dout);
        end
    endtask

    task automatic test_ascending;
        logic [31:0] res; int lat, bc; logic bd;
        do_sort(32'h1080_03FF, 1'b0, res, lat, bc, bd);
        total++;
        if (res !== 32'hFF80_1003) begin bad++; $display("FAIL asc_dout got %h want ff801003", res); end
        total++;
        if (lat !== 6) begin bad++; $display("FAIL asc_latency got %0d want 6", lat); end
        total++;
        if (bc !== 6) begin bad++; $display("FAIL asc_busy_cycles got %0d want 6", bc); end
        total++;
        if (bd !== 1'b0) begin bad++; $display("FAIL asc_busy_at_done got %b want 0", bd); end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL asc_done_width got %b want 0", bus.done); end
    endtask

    task automatic test_descending;
        logic [31:0] res; int lat, bc; logic bd;
        do_sort(32'h1080_03FF, 1'b1, res, lat, bc, bd);
        total++;
        if (res !== 32'h0310_80FF) begin bad++; $display("FAIL desc_dout got %h want 031080ff", res); end
        total++;
        if (lat !== 6) begin bad++; $display("FAIL desc_latency got %0d want 6", lat); end
    endtask

    task automatic test_unsigned_dup;
        logic [31:0] res; int lat, bc; logic bd;
        do_sort(32'h7F80_7F00, 1'b0, res, lat, bc, bd);
        total++;
        if (res !== 32'h807F_7F00) begin bad++; $display("FAIL unsigned_dout got %h want 807f7f00", res); end
        do_sort(32'h0505_0505, 1'b0, res, lat, bc, bd);
        total++;
        if (res !== 32'h0505_0505) begin bad++; $display("FAIL dup_dout got %h want 05050505", res); end
        do_sort(32'h0080_FF80, 1'b1, res, lat, bc, bd);
        total++;
        if (res !== 32'h0080_80FF) begin bad++; $display("FAIL dup_desc_dout got %h want 008080ff", res); end
    endtask

    task automatic test_ignore_busy;
        int ndone = 0;
        logic [31:0] first = 32'h0;
        @(negedge clk);
        bus.din = 32'h0102_0304; bus.desc = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        // Retrigger mid-sort with new operands and opposite order; both must be ignored.
        bus.din = 32'hAA55_00FF; bus.desc = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) first = bus.dout;
            end
            @(negedge clk);
        end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        total++;
        if (first !== 32'h0403_0201) begin bad++; $display("FAIL ignore_result got %h want 04030201", first); end
        total++;
        if (bus.dout !== 32'h0403_0201) begin bad++; $display("FAIL ignore_dout_hold got %h want 04030201", bus.dout); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        logic [31:0] res; int lat, bc; logic bd;
        @(negedge clk);
        bus.din = 32'h4433_2211; bus.desc = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.dout} !== 34'h0) begin
            bad++; $display("FAIL rst_mid_clear got busy=%b done=%b dout=%h want 0 0 0", bus.busy, bus.done, bus.dout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone !== 0) begin bad++; $display("FAIL rst_mid_no_done got %0d want 0", ndone); end
        do_sort(32'h4433_2211, 1'b1, res, lat, bc, bd);
        total++;
        if (res !== 32'h1122_3344) begin bad++; $display("FAIL rst_mid_after got %h want 11223344", res); end
        total++;
        if (lat !== 6) begin bad++; $display("FAIL rst_mid_latency got %0d want 6", lat); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v   [2] = '{32'h0A0B_0C0D, 32'hF000_0F80};
        logic [31:0] exp [2] = '{32'h0D0C_0B0A, 32'hF080_0F00};
        int cyc = 0, last = 0, k = 0;
        @(negedge clk);
        bus.din = v[0]; bus.desc = 1'b0; bus.start = 1'b1;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                total++;
                if (bus.dout !== exp[k % 2]) begin
                    bad++; $display("FAIL b2b_dout[%0d] got %h want %h", k, bus.dout, exp[k % 2]);
                end
                if (k > 0) begin
                    total++;
                    if (cyc - last !== 7) begin bad++; $display("FAIL b2b_period[%0d] got %0d want 7", k, cyc - last); end
                end
                last = cyc;
                k++;
                bus.din = v[k % 2];
            end
        end
        bus.start = 1'b0;
        total++;
        if (k !== 4) begin bad++; $display("FAIL b2b_count got %0d want 4", k); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] d, res, want; logic ds, bd; int lat, bc;
        for (int n = 0; n < 800; n++) begin
            d  = $urandom;
            ds = 1'($urandom_range(0, 1));
            // Squeeze some vectors into a tiny range to force duplicates.
            if (n % 4 == 0) d = d & 32'h0303_0303;
            want = ref_sort(d, ds);
            do_sort(d, ds, res, lat, bc, bd);
            total++;
            if (res !== want || lat !== 6) begin
                bad++; $display("FAIL rand[%0d] din=%h desc=%b got %h lat=%0d want %h lat=6", n, d, ds, res, lat, want);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_descending;
        test_unsigned_dup;
        test_ignore_busy;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
